lcd_write_sequencer: RTL and testbench

Owns the 4-bit character-LCD interface (sf_d[11:8], lcd_e, lcd_rs, lcd_rw) of the computer. After reset it runs the power-on init and configuration sequence. It then accepts command/data bytes from the CPU store path over a valid/ready handshake and emits each byte as two timed nibble strobes. It is the only driver of the LCD pins; the CPU never toggles them directly.

---
 rtl/lcd_write_sequencer_if.sv | 21 ++
 rtl/lcd_write_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_sequencer_if.sv
// CPU-to-LCD byte write handshake: the CPU store path offers a byte, the sequencer accepts it.
interface lcd_write_sequencer_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_rs,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_rs,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Sole driver of the 4-bit character-LCD pins: power-on init, configuration, then CPU bytes
// emitted as two timed nibble strobes with a post-byte wait.
module lcd_write_sequencer #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned NIB_GAP_CYC    = 50,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLR_WAIT_CYC   = 82000,
  parameter int unsigned PWR_WAIT_CYC   = 750000,
  parameter int unsigned INIT_WAIT1_CYC = 205000,
  parameter int unsigned INIT_WAIT2_CYC = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_write_sequencer_if.slave  wr,
  output logic                  init_done,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_e,
  output logic [3:0]            sf_d
);

  // Counter reload values: a state lasts N cycles when loaded with N-1.
  localparam logic [19:0] LdSetup = 20'(SETUP_CYC - 1);
  localparam logic [19:0] LdEHigh = 20'(E_HIGH_CYC - 1);
  localparam logic [19:0] LdGap   = 20'(NIB_GAP_CYC - 1);
  localparam logic [19:0] LdCmd   = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] LdClr   = 20'(CLR_WAIT_CYC - 1);
  localparam logic [19:0] LdPwr   = 20'(PWR_WAIT_CYC - 1);
  localparam logic [19:0] LdInit1 = 20'(INIT_WAIT1_CYC - 1);
  localparam logic [19:0] LdInit2 = 20'(INIT_WAIT2_CYC - 1);

  typedef enum logic [2:0] {
    StPwr,
    StSetup,
    StEHigh,
    StGap,
    StWait,
    StIdle
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  step_q, step_d;       // 0..3 init nibbles, 4..7 config bytes, 8 user byte
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        hi_q, hi_d;           // upper nibble of a byte is in flight
  logic        is_byte_q, is_byte_d;
  logic [3:0]  sf_d_q, sf_d_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rw_q;
  logic        ready_q, ready_d;
  logic        init_done_q, init_done_d;

  logic        cnt_done;
  logic [3:0]  step_nx;
  logic [7:0]  cfg_byte;
  logic [19:0] post_wait;

  assign cnt_done = (cnt_q == 20'd0);
  assign step_nx  = step_q + 4'd1;

  always_comb begin
    cfg_byte = 8'h01;
    case (step_nx)
      4'd4:    cfg_byte = 8'h28;
      4'd5:    cfg_byte = 8'h06;
      4'd6:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  end

  // Clear and return-home commands need the long wait; init nibbles have their own waits.
  always_comb begin
    post_wait = LdCmd;
    if (is_byte_q) begin
      if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) begin
        post_wait = LdClr;
      end
    end else begin
      case (step_q)
        4'd0:    post_wait = LdInit1;
        4'd1:    post_wait = LdInit2;
        default: post_wait = LdCmd;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_done ? cnt_q : cnt_q - 20'd1;
    step_d    = step_q;
    byte_d    = byte_q;
    rs_d      = rs_q;
    hi_d      = hi_q;
    is_byte_d = is_byte_q;
    sf_d_d    = sf_d_q;
    lcd_rs_d  = lcd_rs_q;

    case (state_q)
      StPwr: begin
        if (cnt_done) begin
          step_d    = 4'd0;
          is_byte_d = 1'b0;
          rs_d      = 1'b0;
          state_d   = StSetup;
          cnt_d     = LdSetup;
          sf_d_d    = 4'h3;
          lcd_rs_d  = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_done) begin
          state_d = StEHigh;
          cnt_d   = LdEHigh;
        end
      end
      StEHigh: begin
        if (cnt_done) begin
          if (is_byte_q && hi_q) begin
            state_d = StGap;
            cnt_d   = LdGap;
          end else begin
            state_d = StWait;
            cnt_d   = post_wait;
          end
        end
      end
      StGap: begin
        if (cnt_done) begin
          hi_d     = 1'b0;
          state_d  = StSetup;
          cnt_d    = LdSetup;
          sf_d_d   = byte_q[3:0];
          lcd_rs_d = rs_q;
        end
      end
      StWait: begin
        if (cnt_done) begin
          if (step_q < 4'd3) begin
            step_d   = step_nx;
            state_d  = StSetup;
            cnt_d    = LdSetup;
            sf_d_d   = (step_q == 4'd2) ? 4'h2 : 4'h3;
            lcd_rs_d = 1'b0;
          end else if (step_q < 4'd7) begin
            step_d    = step_nx;
            byte_d    = cfg_byte;
            rs_d      = 1'b0;
            is_byte_d = 1'b1;
            hi_d      = 1'b1;
            state_d   = StSetup;
            cnt_d     = LdSetup;
            sf_d_d    = cfg_byte[7:4];
            lcd_rs_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StIdle: begin
        if (wr.wr_valid) begin
          step_d    = 4'd8;
          byte_d    = wr.wr_data;
          rs_d      = wr.wr_rs;
          is_byte_d = 1'b1;
          hi_d      = 1'b1;
          state_d   = StSetup;
          cnt_d     = LdSetup;
          sf_d_d    = wr.wr_data[7:4];
          lcd_rs_d  = wr.wr_rs;
        end
      end
      default: begin
        state_d = StPwr;
        cnt_d   = LdPwr;
      end
    endcase

    lcd_e_d     = (state_d == StEHigh);
    ready_d     = (state_d == StIdle);
    init_done_d = init_done_q | (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPwr;
      cnt_q       <= LdPwr;
      step_q      <= 4'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      hi_q        <= 1'b0;
      is_byte_q   <= 1'b0;
      sf_d_q      <= 4'h0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rw_q    <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      hi_q        <= hi_d;
      is_byte_q   <= is_byte_d;
      sf_d_q      <= sf_d_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rw_q    <= 1'b0;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign wr.wr_ready = ready_q;
  assign init_done   = init_done_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_rw      = lcd_rw_q;
  assign lcd_e       = lcd_e_q;
  assign sf_d        = sf_d_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened timing; expected nibbles are queued
// as stimulus is driven and popped on each lcd_e rising edge.
module tb_lcd_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] sf_d;

  always #5 clk = ~clk;

  lcd_write_sequencer_if wr_if ();

  lcd_write_sequencer #(
    .SETUP_CYC     (1),
    .E_HIGH_CYC    (2),
    .NIB_GAP_CYC   (3),
    .CMD_WAIT_CYC  (5),
    .CLR_WAIT_CYC  (9),
    .PWR_WAIT_CYC  (10),
    .INIT_WAIT1_CYC(7),
    .INIT_WAIT2_CYC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr_if),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .sf_d     (sf_d)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [4:0] exp_q[$];
  int         first_rise = -1;
  int         last_fall = 0;
  int         hi_cnt = 0;
  logic       e_prev = 1'b0;
  bit         abort_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin monitor: every lcd_e rising edge must match the next queued {rs, nibble}.
  always @(negedge clk) begin
    logic [4:0] e;
    check("lcd_rw", {31'b0, lcd_rw}, 32'd0);
    if (lcd_e === 1'b1 && e_prev === 1'b0) begin
      hi_cnt = 1;
      if (first_rise < 0) first_rise = cyc;
      check("pulse_queued", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("nibble", {27'b0, lcd_rs, sf_d}, {27'b0, e});
      end
    end else if (lcd_e === 1'b1 && e_prev === 1'b1) begin
      hi_cnt++;
    end else if (lcd_e !== 1'b1 && e_prev === 1'b1) begin
      last_fall = cyc;
      if (!abort_pulse) check("e_width", hi_cnt, 32'd2);
      abort_pulse = 1'b0;
    end
    e_prev = lcd_e;
  end

  task automatic push_init();
    logic [3:0] nibs[12];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    foreach (nibs[i]) exp_q.push_back({1'b0, nibs[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lcd_e"}, {31'b0, lcd_e}, 32'd0);
    check({tag, "_sf_d"}, {28'b0, sf_d}, 32'd0);
    check({tag, "_lcd_rs"}, {31'b0, lcd_rs}, 32'd0);
    check({tag, "_wr_ready"}, {31'b0, wr_if.wr_ready}, 32'd0);
    check({tag, "_init_done"}, {31'b0, init_done}, 32'd0);
  endtask

  task automatic wait_init(input int rel);
    int k;
    for (k = 0; k < 500 && init_done !== 1'b1; k++) begin
      check("ready_during_init", {31'b0, wr_if.wr_ready}, 32'd0);
      @(negedge clk);
    end
    check("init_done_reached", {31'b0, init_done}, 32'd1);
    check("init_ready_together", {31'b0, wr_if.wr_ready}, 32'd1);
    check("init_done_gap", cyc - last_fall, 32'd9);
    check("first_rise_delay", first_rise - rel, 32'd11);
    check("init_pulses_all_seen", exp_q.size(), 32'd0);
  endtask

  task automatic wait_ready(input int acc, input int lat, input string tag);
    for (int k = 0; k < 200 && wr_if.wr_ready !== 1'b1; k++) @(negedge clk);
    check(tag, cyc - acc, lat);
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] data, input int lat,
                            input string tag);
    int acc;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = rs;
    wr_if.wr_data  = data;
    exp_q.push_back({rs, data[7:4]});
    exp_q.push_back({rs, data[3:0]});
    @(negedge clk);
    acc = cyc;
    wr_if.wr_valid = 1'b0;
    check({tag, "_ready_drop"}, {31'b0, wr_if.wr_ready}, 32'd0);
    wait_ready(acc, lat, {tag, "_latency"});
  endtask

  initial begin
    int acc, acc2, rel;
    rst            = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_rs    = 1'b0;
    wr_if.wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Power-on init and configuration
    push_init();
    first_rise = -1;
    rel = cyc;
    rst = 1'b0;
    wait_init(rel);

    write_byte(1'b1, 8'h41, 14, "data_41");
    write_byte(1'b0, 8'h01, 18, "cmd_clear");
    write_byte(1'b0, 8'h80, 14, "cmd_80");
    write_byte(1'b0, 8'h02, 18, "cmd_home");

    // Back-to-back with data changed after the accept edge
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h48;
    exp_q.push_back({1'b1, 4'h4});
    exp_q.push_back({1'b1, 4'h8});
    @(negedge clk);
    acc = cyc;
    wr_if.wr_data = 8'h49;
    exp_q.push_back({1'b1, 4'h4});
    exp_q.push_back({1'b1, 4'h9});
    check("b2b_ready_drop", {31'b0, wr_if.wr_ready}, 32'd0);
    wait_ready(acc, 14, "b2b_first_latency");
    @(negedge clk);
    acc2 = cyc;
    check("b2b_second_accepted", {31'b0, wr_if.wr_ready}, 32'd0);
    wr_if.wr_valid = 1'b0;
    wait_ready(acc2, 14, "b2b_second_latency");

    // Reset while lcd_e is high on a user byte; only the upper nibble ever strobes
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h55;
    exp_q.push_back({1'b1, 4'h5});
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    for (int k = 0; k < 50 && lcd_e !== 1'b1; k++) @(negedge clk);
    check("abort_pulse_seen", {31'b0, lcd_e}, 32'd1);
    abort_pulse = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    check("midreset_queue", exp_q.size(), 32'd0);

    // Re-init with wr_valid held from reset release: nothing accepted before init_done
    push_init();
    first_rise     = -1;
    rel            = cyc;
    rst            = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h5A;
    wait_init(rel);
    exp_q.push_back({1'b1, 4'h5});
    exp_q.push_back({1'b1, 4'hA});
    @(negedge clk);
    acc = cyc;
    check("held_valid_accepted", {31'b0, wr_if.wr_ready}, 32'd0);
    wr_if.wr_valid = 1'b0;
    wait_ready(acc, 14, "held_valid_latency");

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
